// File: rtl/mips_core_pkg.sv
// Shared core package: fetch-queue entry type and default sizing.
package mips_core_pkg;

  localparam int unsigned FETCH_QUEUE_DEPTH = 8;
  localparam int unsigned FQ_ADDR_WIDTH     = 32;
  localparam int unsigned FQ_DATA_WIDTH     = 32;

  // One buffered fetch slot: PC plus instruction word.
  typedef struct packed {
    logic [FQ_ADDR_WIDTH-1:0] pc;
    logic [FQ_DATA_WIDTH-1:0] inst;
  } fq_entry_t;

  // Occupancy counter width for a queue of the given depth (0..depth).
  function automatic int unsigned fq_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_ptr_ctrl.sv
// Fetch-queue pointer and occupancy bookkeeping (module fq_ptr_ctrl).
module fq_ptr_ctrl
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH)-1:0] o_wr_ptr,
  output logic [$clog2(DEPTH)-1:0] o_rd_ptr,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full_c,
  output logic                     o_empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = fq_cnt_width(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally at DEPTH; reset/flush return everything to zero.
  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Status flags derived from occupancy.
  always_comb begin
    o_full_c  = (r_count == CNT_W'(DEPTH));
    o_empty_c = (r_count == '0);
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: show-ahead FIFO of {pc, inst} between i-cache and decode.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH      = FETCH_QUEUE_DEPTH,
  parameter int unsigned ADDR_WIDTH = FQ_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = FQ_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_inst,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [ADDR_WIDTH-1:0]    out_pc,
  output logic [DATA_WIDTH-1:0]    out_inst,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } fq_slot_t;

  fq_slot_t         r_mem [DEPTH];
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;

  // Handshakes; flush suppresses both sides. A bypassed-and-consumed pair is never written.
  always_comb begin
`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass = w_empty & in_valid & ~flush;
`else
    w_bypass = 1'b0;
`endif
    w_push = in_valid & ~w_full & ~flush & ~(w_bypass & out_ready);
    w_pop  = ~w_empty & out_ready & ~flush;
  end

  fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk       (clk),
    .i_rst     (rst),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .o_wr_ptr  (w_wr_ptr),
    .o_rd_ptr  (w_rd_ptr),
    .o_count   (count),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_ptr] <= fq_slot_t'({in_pc, in_inst});
  end

  // Show-ahead head selection, zeroed when nothing is presented.
  always_comb begin
    in_ready  = ~w_full;
    out_valid = ~w_empty | w_bypass;
    out_pc    = '0;
    out_inst  = '0;
    if (!w_empty) begin
      out_pc   = r_mem[w_rd_ptr].pc;
      out_inst = r_mem[w_rd_ptr].inst;
    end else if (w_bypass) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed literal checks.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready = 1'b0;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  pair_t q[$];

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare all outputs against the model mid-cycle, then advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl, input logic r);
    logic  byp, e_valid, push, pop;
    logic [31:0] e_pc, e_inst;
    pair_t p;
    in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl; rst = r;
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (q.size() == 0) && v && !fl;
`else
    byp = 1'b0;
`endif
    e_valid = (q.size() != 0) || byp;
    e_pc = '0; e_inst = '0;
    if (q.size() != 0) begin e_pc = q[0].pc; e_inst = q[0].inst; end
    else if (byp)      begin e_pc = pc;      e_inst = inst;      end
    chk("in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("out_pc",    64'(out_pc),    64'(e_pc));
    chk("out_inst",  64'(out_inst),  64'(e_inst));
    chk("count",     64'(count),     64'(q.size()));
    push = v && (q.size() != DEPTH) && !fl && !(byp && ordy);
    pop  = (q.size() != 0) && ordy && !fl;
    @(posedge clk);
    if (r || fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin p.pc = pc; p.inst = inst; q.push_back(p); end
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; rst = 1'b0;
    #1;
  endtask

  initial begin
    // Bring-up reset without comparisons (state is unknown before it).
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();

    // Reset values.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);

    // Three pushes stalled, then drain in order.
    step(1'b1, 32'h100, 32'hA0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h108, 32'hA2, 1'b0, 1'b0, 1'b0);
    idle();
    chk("three_count", 64'(count), 64'd3);
    chk("head0_pc", 64'(out_pc), 64'h100);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("head1_pc", 64'(out_pc), 64'h104);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("head2_pc", 64'(out_pc), 64'h108);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("drained_valid", 64'(out_valid), 64'd0);

    // Fill to full, drop a 9th, pop one.
    for (int i = 0; i < 8; i++) step(1'b1, 32'h300 + 32'(4 * i), 32'(i), 1'b0, 1'b0, 1'b0);
    idle();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd8);
    step(1'b1, 32'h900, 32'h9, 1'b0, 1'b0, 1'b0);
    idle();
    chk("drop9_count", 64'(count), 64'd8);
    step(1'b1, 32'h904, 32'h9, 1'b1, 1'b0, 1'b0);
    idle();
    chk("after_pop_in_ready", 64'(in_ready), 64'd1);
    chk("after_pop_count", 64'(count), 64'd7);
    chk("after_pop_head", 64'(out_pc), 64'h304);

    // Steady streaming at count 4 across two wraps.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h400 + 32'(4 * i), 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 4; i < 24; i++) step(1'b1, 32'h400 + 32'(4 * i), 32'(i), 1'b1, 1'b0, 1'b0);
    idle();
    chk("steady_count", 64'(count), 64'd4);
    chk("steady_head", 64'(out_pc), 64'h400 + 64'(4 * 20));

    // Flush at count 5 with a same-cycle push.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + 32'(4 * i), 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b1, 1'b0);
    idle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h600 + 32'(4 * i), 32'(i), i[0], 1'b0, 1'b0);
    step(1'b1, 32'h700, 32'h7, 1'b1, 1'b0, 1'b1);
    idle();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_pc", 64'(out_pc), 64'd0);
    chk("mid_rst_out_inst", 64'(out_inst), 64'd0);

    // Push into an empty queue with decode ready.
    in_valid = 1'b1; in_pc = 32'h200; in_inst = 32'h2; out_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_same_valid", 64'(out_valid), 64'd1);
    chk("byp_same_pc", 64'(out_pc), 64'h200);
    step(1'b1, 32'h200, 32'h2, 1'b1, 1'b0, 1'b0);
    idle();
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("nobyp_same_valid", 64'(out_valid), 64'd0);
    step(1'b1, 32'h200, 32'h2, 1'b1, 1'b0, 1'b0);
    idle();
    chk("nobyp_next_valid", 64'(out_valid), 64'd1);
    chk("nobyp_next_pc", 64'(out_pc), 64'h200);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the i-cache output / fetch PC and the decode stage. It absorbs i-cache hit bursts while decode is stalled, so fetch keeps running.
- Stores {pc, inst} pairs and presents the oldest pair show-ahead to decode.
- On branch-mispredict flush, every buffered entry is discarded in one cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- ADDR_WIDTH, 32, PC width.
- DATA_WIDTH, 32, instruction width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock; synchronous, active-high.
- flush  in  1  discard all entries and any same-cycle push.
- in_valid  in  1  fetch offers a pair (i-cache hit).
- in_pc  in  ADDR_WIDTH  PC of the offered instruction.
- in_inst  in  DATA_WIDTH  offered instruction word.
- in_ready  out  1  queue can accept this cycle.
- out_valid  out  1  head entry valid.
- out_pc  out  ADDR_WIDTH  head PC.
- out_inst  out  DATA_WIDTH  head instruction.
- out_ready  in  1  decode consumes head (i.e. not stalled).
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- State:
  - storage array of DEPTH entries;
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count register, 0..DEPTH.
- Handshakes:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). It is not asserted when full even if out_ready is high, so there is no full-bypass path.
- out_valid = (count != 0). out_pc/out_inst read the array at rd_ptr combinationally (show-ahead).
- When out_valid = 0, out_pc and out_inst are driven to 0.
- Latency: a push into an empty queue appears at the outputs on the next cycle (1-cycle latency).
- count update:
  - push only: count+1.
  - pop only: count-1.
  - both: unchanged.
  - Pointers advance independently on push and pop.
- Full with out_ready high: pop only. in_ready stays low that cycle and rises the next cycle.
- Empty with out_ready high: no pop and no underflow. Pointers do not move.
- Wrap-around: pointers roll from DEPTH-1 to 0. Ordering is strictly FIFO across the wrap.
- Flush:
  - Next cycle: wr_ptr = rd_ptr = 0, count = 0, so out_valid = 0 and in_ready = 1.
  - A push or pop in the flush cycle is ignored.
  - Flush takes priority over all other events.
- Reset (rst high at posedge): same state as flush, and dominates flush.
  - Reset values: in_ready = 1, out_valid = 0, out_pc = 0, out_inst = 0, count = 0.
  - A reset asserted mid-burst loses all entries.
- Array contents are not reset. Only the pointers and count are.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count == 0 and in_valid & ~flush, the input is forwarded combinationally to the outputs that same cycle:
  - out_valid = 1, out_pc = in_pc, out_inst = in_inst.
  - If out_ready is also high, the pair is consumed without being written, and pointers and count stay unchanged.
  - If out_ready is low, the pair is written normally.
  - Zero-cycle latency when empty.
- Undefined: no bypass; an empty queue always adds 1 cycle of latency as described above.

Decomposition:
- Shared package mips_core_pkg gains:
  - typedef fq_entry_t (packed struct {pc, inst});
  - constant FETCH_QUEUE_DEPTH.
- Optional sub-module fq_ptr_ctrl: pointer and count bookkeeping only (push/pop/flush/rst in; wr_ptr, rd_ptr, count, full, empty out). The top level holds the array and output muxing.

Test Plan:
- Push PCs 0x100, 0x104, 0x108 with out_ready=0, then raise out_ready:
  - count reaches 3;
  - outputs present 0x100, 0x104, 0x108 on consecutive cycles;
  - out_valid falls after the third pop.
- Fill 8 entries (out_ready=0) -> in_ready=0 and count=8. A 9th in_valid is dropped. Pop one -> in_ready=1 on the next cycle.
- Steady state with count=4, in_valid=1 and out_ready=1 for 20 cycles -> count stays 4, pointers wrap twice, and output order equals input order.
- count=5, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, and the flushed-cycle pair never appears.
- Assert rst for 1 cycle during streaming -> next cycle count=0, in_ready=1, out_pc=0, out_inst=0.
- With FETCH_QUEUE_BYPASS_EN defined, push 0x200 into the empty queue with out_ready=1 -> out_pc=0x200 in the same cycle and count stays 0. Without the macro -> out_valid=1 on the next cycle.
